dma_rawp_scheduler: RTL and testbench
=====================================

# dma_rawp_scheduler

Round-robin scheduler that shares the raw (non-Wishbone) port of the dual-port DMA RAM among several sample producers, such as the frequency-meter channels. Accepted 32-bit words are written into a power-of-two ring region of the RAM. The block tracks the write pointer against a CPU-supplied read pointer, applies back-pressure when the ring is full, and raises a fill-level interrupt. The CPU drains the ring through the RAM's Wishbone port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- RAW_ADDR_WIDTH, 9, raw-port word address width (matches RAM: 512 words per unit)
- RING_BASE, 0, first word address of the ring
- RING_WORDS, 256, ring size in words; power of two; RING_BASE+RING_WORDS ≤ 2^RAW_ADDR_WIDTH
- IRQ_THRESH, 128, level at or above which irq_o asserts (1..RING_WORDS)

Ports (PW = $clog2(RING_WORDS)+1):
- rawp_clk  in  1  sole clock; same clock as the RAM raw port
- rst_n  in  1  asynchronous, active-low reset
- enable_i  in  1  scheduler runs when 1; when 0, no new grants are issued
- clear_i  in  1  synchronous ring flush
- req_valid_i  in  NUM_REQ  per-requester word valid
- req_data_i  in  NUM_REQ*32  per-requester data; requester k occupies [32k+31:32k]
- req_ready_o  out  NUM_REQ  one-hot accept pulse
- rawp_adr_o  out  RAW_ADDR_WIDTH  RAM raw-port word address
- rawp_dat_o  out  32  RAM raw-port write data
- rawp_we_o  out  1  RAM raw-port write enable
- rawp_stall_i  in  1  RAM raw-port stall
- rd_ptr_i  in  PW  CPU read pointer, with wrap bit
- wr_ptr_o  out  PW  write pointer, with wrap bit
- level_o  out  PW  words held, equal to wr_ptr_o − rd_ptr_i modulo 2^PW
- full_o  out  1  level_o == RING_WORDS
- irq_o  out  1  level_o ≥ IRQ_THRESH

## Operation
- FSM states:
  - IDLE: if enable_i, !full_o and any req_valid_i:
    - pick the winner k, the first valid requester at or after rr_ptr, cyclically
    - pulse req_ready_o[k] for one cycle
    - latch req_data_i[k] and k
    - set rr_ptr ← k+1 (mod NUM_REQ)
    - go to WRITE
  - WRITE: drive rawp_we_o=1, rawp_adr_o=RING_BASE+wr_ptr[PW-2:0], rawp_dat_o=latched word.
    - If !rawp_stall_i: wr_ptr ← wr_ptr+1, which wraps naturally at 2^PW; go to IDLE.
    - Otherwise hold all outputs.
- Transfer rule: a word is transferred when req_valid_i[k] & req_ready_o[k]. Requesters must hold data while valid.
- Full: no grant is issued while full_o is 1. The ring is never overwritten.
- The block does not check rd_ptr_i. A CPU value giving level > RING_WORDS is a software error; behaviour is then undefined except that the address always stays inside the ring.
- clear_i has priority over every other action:
  - wr_ptr ← 0, rr_ptr ← 0, state ← IDLE
  - any latched word is discarded and no write is issued that cycle
  - req_ready_o is 0 that cycle
  - software must also zero its read pointer.
- Dropping enable_i in WRITE does not abort the write in progress; the block finishes it and then idles.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, wr_ptr_o 0
  - req_ready_o 0, rawp_we_o 0, rawp_adr_o RING_BASE, rawp_dat_o 0
  - level_o, full_o, irq_o derived combinationally (0 when rd_ptr_i=0)
- req_ready_o is combinational from IDLE state, valid, enable_i and full_o. All other outputs except level_o/full_o/irq_o are registered.
- Latency: grant at cycle N; write strobe in cycle N+1 with no stall; wr_ptr_o updates at the end of N+1.
- Peak throughput: one word per 2 cycles.
- wr_ptr_o, level_o and irq_o update the cycle after the write completes.

## Configuration
- DMA_SCHED_TAG_EN:
  - Defined: rawp_dat_o[31:32−TW] is replaced by the winning requester index, with TW=$clog2(NUM_REQ); the remaining bits come from the requester.
  - Undefined: words are written unmodified.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, WRITE)
  - the ring_level function (wr−rd modulo 2^PW)
  - a tag-width constant function.
- One sub-module, rr_arbiter (NUM_REQ-wide round-robin priority select with rotating pointer), returns a one-hot grant and its index.
- Everything else is inline.

## Test plan
- Single requester 0 writing 0xA5A5_0001: rawp_we_o one cycle later at RING_BASE, with data 0xA5A5_0001 (with DMA_SCHED_TAG_EN: 0x25A5_0001 for NUM_REQ=4) → wr_ptr_o=1, level_o=1.
- All 4 requesters valid continuously: grant order 0,1,2,3,0,…; one write every 2 cycles.
- RING_WORDS=256, rd_ptr_i=0: after 256 writes full_o=1 and req_ready_o stays 0. Setting rd_ptr_i=1 gives exactly one more write, at address RING_BASE+0, with wr_ptr_o=257 (wrap bit set).
- IRQ_THRESH=128: irq_o rises the cycle after the 128th write and falls when rd_ptr_i advances to 1.
- rawp_stall_i held high for 3 cycles in WRITE: address and data held, rawp_we_o high for 4 cycles, exactly one pointer increment.
- clear_i asserted in WRITE, and separately rst_n pulsed mid-stream: no write that cycle, wr_ptr_o=0, next grant goes to requester 0; all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/dma_rawp_scheduler_pkg.sv
// Shared types and helpers for the raw-port DMA ring scheduler.
// Holds the FSM encoding, the ring fill-level arithmetic and the tag-width helper.
// Pure declarations: no logic, no latency, no flow control.
package dma_rawp_scheduler_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } sched_state_t;

  // Words held in the ring: (wr - rd) modulo 2^pw, pointers carry a wrap bit.
  function automatic logic [31:0] ring_level(input logic [31:0] wr,
                                             input logic [31:0] rd,
                                             input int unsigned pw);
    logic [31:0] mask;
    mask = (pw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pw) - 32'd1);
    return (wr - rd) & mask;
  endfunction

  // Bits needed to carry a requester index in the top of a data word.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dma_rawp_scheduler_if.sv
// Bundle of the requester handshake and the RAM raw-port bus.
// master: the scheduler view; slave: the producers plus RAM view.
// Requester side is valid/ready, RAM side is write strobe with stall.
interface dma_rawp_scheduler_if
  import dma_rawp_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int RAW_ADDR_WIDTH = 9
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [RAW_ADDR_WIDTH-1:0] rawp_adr;
  logic [DATA_W-1:0]         rawp_dat;
  logic                      rawp_we;
  logic                      rawp_stall;

  modport master (
    input  req_valid, req_data, rawp_stall,
    output req_ready, rawp_adr, rawp_dat, rawp_we
  );

  modport slave (
    output req_valid, req_data, rawp_stall,
    input  req_ready, rawp_adr, rawp_dat, rawp_we
  );
endinterface

// File: rtl/dma_rawp_scheduler_rr_arbiter.sv
// Round-robin priority select: first requester at or after ptr_i, cyclically.
// Latency: purely combinational, zero cycles.
// No flow control of its own; the caller decides whether the grant is used.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan N candidates starting at the pointer; the first valid one wins.
  always_comb begin
    logic          found;
    logic [IW:0]   cand_w;
    logic [IW-1:0] cand;
    gnt_o  = '0;
    idx_o  = '0;
    found  = 1'b0;
    cand_w = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand_w = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand_w >= (IW+1)'(N)) begin
        cand_w = cand_w - (IW+1)'(N);
      end
      cand = cand_w[IW-1:0];
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/dma_rawp_scheduler.sv
// Round-robin writer of producer words into a power-of-two ring on the RAM raw port.
// Latency: grant in cycle N, write strobe in N+1, pointer/level update after the write; 1 word / 2 cycles.
// Backpressure: no grant while the ring is full or disabled; rawp_stall_i holds the write. Optional DMA_SCHED_TAG_EN tags words with the requester index.
module dma_rawp_scheduler
  import dma_rawp_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int RAW_ADDR_WIDTH = 9,
  parameter int RING_BASE      = 0,
  parameter int RING_WORDS     = 256,
  parameter int IRQ_THRESH     = 128,
  localparam int PW            = $clog2(RING_WORDS) + 1
) (
  input  logic                 rawp_clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 clear_i,
  dma_rawp_scheduler_if.master bus,
  input  logic [PW-1:0]        rd_ptr_i,
  output logic [PW-1:0]        wr_ptr_o,
  output logic [PW-1:0]        level_o,
  output logic                 full_o,
  output logic                 irq_o
);

  localparam int IW = $clog2(NUM_REQ);

  sched_state_t              state_q, state_d;
  logic [IW-1:0]             rr_q, rr_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [RAW_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_W-1:0]         dat_q, dat_d;
  logic                      we_q, we_d;

  logic [NUM_REQ-1:0]        arb_gnt;
  logic [IW-1:0]             arb_idx;
  logic                      arb_any;
  logic [PW-1:0]             level;
  logic                      full;
  logic                      grant_ok;
  logic [IW+4:0]             win_base;
  logic [DATA_W-1:0]         raw_win;
  logic [DATA_W-1:0]         win_dat;
  logic [RAW_ADDR_WIDTH-1:0] ring_adr;

  rr_arbiter #(
    .N (NUM_REQ),
    .IW(IW)
  ) u_arb (
    .req_i(bus.req_valid),
    .ptr_i(rr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx),
    .any_o(arb_any)
  );

  // Fill level against the CPU read pointer; full/irq follow it combinationally.
  assign level = PW'(ring_level(32'(wr_ptr_q), 32'(rd_ptr_i), PW));
  assign full  = (level == PW'(RING_WORDS));

  // Grant only from IDLE; clear wins over everything, so it also blocks the accept.
  assign grant_ok      = (state_q == ST_IDLE) && enable_i && !full && !clear_i && arb_any;
  assign bus.req_ready = grant_ok ? arb_gnt : '0;

  // Winner's data word and the ring slot it goes to (offset wraps inside the ring).
  assign win_base = {arb_idx, 5'b0};
  assign raw_win  = bus.req_data[win_base +: DATA_W];
  assign ring_adr = RAW_ADDR_WIDTH'(RING_BASE) + RAW_ADDR_WIDTH'(wr_ptr_q[PW-2:0]);

`ifdef DMA_SCHED_TAG_EN
  localparam int TW = tag_width(NUM_REQ);
  assign win_dat = {TW'(arb_idx), raw_win[DATA_W-1-TW:0]};
`else
  assign win_dat = raw_win;
`endif

  // Next-state logic: clear first, then the IDLE grant / WRITE completion sequence.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    if (clear_i) begin
      state_d  = ST_IDLE;
      rr_d     = '0;
      wr_ptr_d = '0;
      we_d     = 1'b0;
      adr_d    = RAW_ADDR_WIDTH'(RING_BASE);
      dat_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_ok) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            adr_d   = ring_adr;
            dat_d   = win_dat;
            rr_d    = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
        ST_WRITE: begin
          // enable_i is deliberately ignored here: a started write always finishes.
          if (!bus.rawp_stall) begin
            state_d  = ST_IDLE;
            we_d     = 1'b0;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          we_d    = 1'b0;
        end
      endcase
    end
  end

  // State and registered RAM-port outputs.
  always_ff @(posedge rawp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      adr_q    <= RAW_ADDR_WIDTH'(RING_BASE);
      dat_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
    end
  end

  // Strobe is masked by clear so a flushed word never reaches the RAM.
  assign bus.rawp_we  = we_q & ~clear_i;
  assign bus.rawp_adr = adr_q;
  assign bus.rawp_dat = dat_q;

  assign wr_ptr_o = wr_ptr_q;
  assign level_o  = level;
  assign full_o   = full;
  assign irq_o    = (level >= PW'(IRQ_THRESH));

endmodule

// File: tb/tb_dma_rawp_scheduler.sv
// Directed bench for dma_rawp_scheduler with a write scoreboard.
// Stimulus pushes producer words and the expected RAM writes; a monitor checks every write.
// Covers reset, single word, round-robin order, fill/full/irq, stall, clear and async reset.
module tb_dma_rawp_scheduler;

  localparam int NREQ  = 4;
  localparam int AW    = 9;
  localparam int BASE  = 16;
  localparam int WORDS = 256;
  localparam int THR   = 128;
  localparam int PW    = 9;

`ifdef DMA_SCHED_TAG_EN
  localparam logic [31:0] TAG_MASK = 32'hC000_0000;
`else
  localparam logic [31:0] TAG_MASK = 32'h0000_0000;
`endif

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } wr_t;

  logic          rawp_clk = 1'b0;
  logic          rst_n;
  logic          enable_i;
  logic          clear_i;
  logic [PW-1:0] rd_ptr_i;
  logic [PW-1:0] wr_ptr_o;
  logic [PW-1:0] level_o;
  logic          full_o;
  logic          irq_o;

  wr_t         exp_q[$];
  logic [31:0] src_q[NREQ][$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 rawp_clk = ~rawp_clk;

  dma_rawp_scheduler_if #(.NUM_REQ(NREQ), .RAW_ADDR_WIDTH(AW)) bus ();

  dma_rawp_scheduler #(
    .NUM_REQ       (NREQ),
    .RAW_ADDR_WIDTH(AW),
    .RING_BASE     (BASE),
    .RING_WORDS    (WORDS),
    .IRQ_THRESH    (THR)
  ) dut (
    .rawp_clk(rawp_clk),
    .rst_n   (rst_n),
    .enable_i(enable_i),
    .clear_i (clear_i),
    .bus     (bus),
    .rd_ptr_i(rd_ptr_i),
    .wr_ptr_o(wr_ptr_o),
    .level_o (level_o),
    .full_o  (full_o),
    .irq_o   (irq_o)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_dat(input logic [1:0] k, input logic [31:0] d);
    return (d & ~TAG_MASK) | ({k, 30'b0} & TAG_MASK);
  endfunction

  task automatic push_src(input int k, input logic [31:0] d);
    src_q[k].push_back(d);
  endtask

  task automatic push_exp(input int k, input logic [31:0] d, input int off);
    wr_t e;
    e.adr = AW'(BASE + off);
    e.dat = exp_dat(2'(k), d);
    exp_q.push_back(e);
  endtask

  task automatic push_word(input int k, input logic [31:0] d, input int off);
    push_src(k, d);
    push_exp(k, d, off);
  endtask

  task automatic wait_ready(input string nm, input logic [NREQ-1:0] want, input int bound);
    int c = 0;
    do begin
      @(negedge rawp_clk);
      c++;
    end while (bus.req_ready !== want && c < bound);
    check(nm, 64'(bus.req_ready), 64'(want));
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      @(negedge rawp_clk);
      c++;
    end
    check(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Producer model: hold each word while valid, advance on an observed accept.
  initial begin : driver
    logic [NREQ-1:0] acc;
    logic [31:0]     dummy;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge rawp_clk);
      acc = rst_n ? (bus.req_ready & bus.req_valid) : '0;
      @(posedge rawp_clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (acc[k] && src_q[k].size() > 0) dummy = src_q[k].pop_front();
        bus.req_valid[k]         = (src_q[k].size() > 0);
        bus.req_data[k*32 +: 32] = (src_q[k].size() > 0) ? src_q[k][0] : 32'h0;
      end
    end
  end

  // Scoreboard monitor: every completed RAM write must match the next expected one.
  always @(negedge rawp_clk) begin
    if (rst_n && bus.rawp_we && !bus.rawp_stall) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write",
                 bus.rawp_adr, bus.rawp_dat);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_adr", 64'(bus.rawp_adr), 64'(e.adr));
        check("wr_dat", 64'(bus.rawp_dat), 64'(e.dat));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  wc;
    bit  done;
    rst_n          = 1'b0;
    enable_i       = 1'b0;
    clear_i        = 1'b0;
    rd_ptr_i       = '0;
    bus.rawp_stall = 1'b0;

    // Reset values.
    #12;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_we", 64'(bus.rawp_we), 64'd0);
    check("rst_adr", 64'(bus.rawp_adr), 64'(BASE));
    check("rst_dat", 64'(bus.rawp_dat), 64'd0);
    check("rst_wr_ptr", 64'(wr_ptr_o), 64'd0);
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    @(posedge rawp_clk); #2;
    rst_n    = 1'b1;
    enable_i = 1'b1;

    // Single word from requester 0: write one cycle after the grant.
    @(negedge rawp_clk);
    push_word(0, 32'hA5A5_0001, 0);
    wait_ready("t1_grant", 4'b0001, 20);
    check("t1_level_at_grant", 64'(level_o), 64'd0);
    @(negedge rawp_clk);
    check("t1_we", 64'(bus.rawp_we), 64'd1);
    check("t1_adr", 64'(bus.rawp_adr), 64'(BASE));
    check("t1_ready_in_write", 64'(bus.req_ready), 64'd0);
    @(negedge rawp_clk);
    check("t1_we_off", 64'(bus.rawp_we), 64'd0);
    check("t1_wr_ptr", 64'(wr_ptr_o), 64'd1);
    check("t1_level", 64'(level_o), 64'd1);

    // Clear while idle resets pointers.
    @(posedge rawp_clk); #2 clear_i = 1'b1;
    @(posedge rawp_clk); #2 clear_i = 1'b0;
    @(negedge rawp_clk);
    check("clr_wr_ptr", 64'(wr_ptr_o), 64'd0);
    check("clr_level", 64'(level_o), 64'd0);

    // All four requesters valid: grants 0,1,2,3,0,1,2,3, one every two cycles.
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < NREQ; k++)
        push_word(k, 32'hC000_0000 + 32'(k * 256 + j), j * 4 + k);
    wait_ready("rr_first", 4'b0001, 20);
    for (int i = 0; i < 16; i++) begin
      check("rr_ready", 64'(bus.req_ready),
            (i % 2 == 0) ? 64'(1 << ((i / 2) % 4)) : 64'd0);
      check("rr_we", 64'(bus.rawp_we), 64'(i % 2));
      if (i < 15) @(negedge rawp_clk);
    end
    @(negedge rawp_clk);
    check("rr_wr_ptr", 64'(wr_ptr_o), 64'd8);

    // Stall held three cycles: address/data held, one pointer increment.
    push_word(2, 32'h1234_5678, 8);
    wait_ready("st_grant", 4'b0100, 20);
    @(posedge rawp_clk); #2 bus.rawp_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge rawp_clk);
      check("st_we", 64'(bus.rawp_we), 64'd1);
      check("st_adr", 64'(bus.rawp_adr), 64'(BASE + 8));
      check("st_dat", 64'(bus.rawp_dat), 64'(exp_dat(2'd2, 32'h1234_5678)));
      check("st_wr_ptr_hold", 64'(wr_ptr_o), 64'd8);
    end
    @(posedge rawp_clk); #2 bus.rawp_stall = 1'b0;
    @(negedge rawp_clk);
    check("st_we_last", 64'(bus.rawp_we), 64'd1);
    @(negedge rawp_clk);
    check("st_we_off", 64'(bus.rawp_we), 64'd0);
    check("st_wr_ptr", 64'(wr_ptr_o), 64'd9);

    // Clear during WRITE: the word is dropped, round-robin restarts at 0.
    push_src(1, 32'hDEAD_0001);
    wait_ready("cw_grant", 4'b0010, 20);
    @(posedge rawp_clk); #2 clear_i = 1'b1;
    @(negedge rawp_clk);
    check("cw_we", 64'(bus.rawp_we), 64'd0);
    check("cw_ready", 64'(bus.req_ready), 64'd0);
    @(posedge rawp_clk); #2 clear_i = 1'b0;
    @(negedge rawp_clk);
    check("cw_wr_ptr", 64'(wr_ptr_o), 64'd0);
    check("cw_we_after", 64'(bus.rawp_we), 64'd0);
    check("cw_level", 64'(level_o), 64'd0);
    push_word(0, 32'h0000_AAAA, 0);
    push_word(3, 32'h3333_0003, 1);
    wait_drain("cw_drain", 40);
    @(negedge rawp_clk);
    check("cw_wr_ptr2", 64'(wr_ptr_o), 64'd2);

    // Fill to the irq threshold.
    @(posedge rawp_clk); #2 clear_i = 1'b1;
    @(posedge rawp_clk); #2 clear_i = 1'b0;
    @(negedge rawp_clk);
    check("fill_start", 64'(wr_ptr_o), 64'd0);
    for (int i = 0; i < 128; i++) push_word(0, 32'h5000_0000 + 32'(i), i);
    wc   = 0;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge rawp_clk);
      if (wc == 127 && bus.rawp_we) check("irq_before", 64'(irq_o), 64'd0);
      if (wc == 128) begin
        check("irq_after", 64'(irq_o), 64'd1);
        done = 1'b1;
      end else if (bus.rawp_we && !bus.rawp_stall) begin
        wc++;
      end
    end
    check("irq_wait_done", 64'(done), 64'd1);
    check("irq_level", 64'(level_o), 64'd128);
    check("irq_full", 64'(full_o), 64'd0);
    rd_ptr_i = 9'd1;
    #1;
    check("irq_fall", 64'(irq_o), 64'd0);
    check("irq_level127", 64'(level_o), 64'd127);
    rd_ptr_i = 9'd0;
    #1;
    check("irq_back", 64'(irq_o), 64'd1);

    // Fill to full, then release exactly one slot.
    for (int i = 128; i < 256; i++) push_word(0, 32'h5000_0000 + 32'(i), i);
    push_src(0, 32'h7777_0001);
    push_src(0, 32'h7777_0002);
    wait_drain("full_drain", 1000);
    @(negedge rawp_clk);
    check("full_wr_ptr", 64'(wr_ptr_o), 64'd256);
    check("full_level", 64'(level_o), 64'd256);
    check("full_flag", 64'(full_o), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge rawp_clk);
      check("full_no_ready", 64'(bus.req_ready), 64'd0);
    end
    push_exp(0, 32'h7777_0001, 0);
    @(posedge rawp_clk); #2 rd_ptr_i = 9'd1;
    wait_drain("wrap_drain", 20);
    @(negedge rawp_clk);
    check("wrap_wr_ptr", 64'(wr_ptr_o), 64'd257);
    check("wrap_full", 64'(full_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge rawp_clk);
      check("wrap_no_ready", 64'(bus.req_ready), 64'd0);
    end

    // Async reset in the middle of a write.
    push_word(1, 32'h1111_0001, 1);
    push_src(2, 32'h2222_0002);
    @(posedge rawp_clk); #2 rd_ptr_i = 9'd257;
    wait_ready("ar_grant2", 4'b0100, 20);
    @(posedge rawp_clk); #2;
    rst_n    = 1'b0;
    enable_i = 1'b0;
    #1;
    check("ar_we", 64'(bus.rawp_we), 64'd0);
    check("ar_adr", 64'(bus.rawp_adr), 64'(BASE));
    check("ar_dat", 64'(bus.rawp_dat), 64'd0);
    check("ar_wr_ptr", 64'(wr_ptr_o), 64'd0);
    rd_ptr_i = 9'd0;
    #1;
    check("ar_level", 64'(level_o), 64'd0);
    check("ar_irq", 64'(irq_o), 64'd0);
    push_src(3, 32'h3333_0007);
    push_exp(0, 32'h7777_0002, 0);
    push_exp(3, 32'h3333_0007, 1);
    @(posedge rawp_clk);
    @(posedge rawp_clk); #2;
    rst_n    = 1'b1;
    enable_i = 1'b1;
    wait_drain("ar_drain", 40);
    @(negedge rawp_clk);
    check("ar_wr_ptr2", 64'(wr_ptr_o), 64'd2);
    check("ar_level2", 64'(level_o), 64'd2);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
